// File: rtl/afifo_axis_reader_pkg.sv
// rtl/afifo_axis_reader_pkg.sv - shared widths, FSM states and tkeep helper for the FIFO-to-AXIS reader
package fifo_axis_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  function automatic int word_width(input int data_w, input int bytes_per_word);
    return data_w * bytes_per_word;
  endfunction

  function automatic int keep_width(input int bytes_per_word);
    return bytes_per_word;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Low nbytes lanes valid; used for the partial word pushed on flush.
  function automatic logic [31:0] keep_mask(input logic [31:0] nbytes);
    return (32'd1 << nbytes) - 32'd1;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - 2-entry registered output slice with occupancy count
module axis_skid_buf #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop, push;

  assign in_ready  = (cnt_q < 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = ent0_q;
  assign count     = cnt_q;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    pop    = out_valid && out_ready;
    push   = in_valid && in_ready;
    case ({pop, push})
      2'b10: begin
        ent0_d = ent1_q;
        ent1_d = '0;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd0) ent0_d = in_data;
        else               ent1_d = in_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b11: begin
        // Head leaves while a new beat arrives; occupancy is unchanged.
        if (cnt_q == 2'd1) begin
          ent0_d = in_data;
        end else begin
          ent0_d = ent1_q;
          ent1_d = in_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/afifo_axis_reader.sv
// rtl/afifo_axis_reader.sv - drains an 8-bit FIFO and packs bytes into AXI-Stream words with packet framing
module afifo_axis_reader
  import fifo_axis_defs::*;
#(
  parameter int DATA_W         = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int PKT_WORDS      = 256,
  parameter int CNT_W          = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             flush,
  input  logic [DATA_W-1:0]                fifo_dout,
  input  logic                             fifo_empty,
  input  logic [CNT_W-1:0]                 fifo_rd_data_count,
  output logic                             fifo_rd_en,
  output logic [DATA_W*BYTES_PER_WORD-1:0] m_axis_tdata,
  output logic [BYTES_PER_WORD-1:0]        m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             busy,
  output logic [15:0]                      pkt_done_cnt,
  output logic [CNT_W-1:0]                 fill_level
);

  localparam int WORD_W = word_width(DATA_W, BYTES_PER_WORD);
  localparam int KEEP_W = keep_width(BYTES_PER_WORD);
  localparam int BI_W   = idx_width(BYTES_PER_WORD);
  localparam int WI_W   = idx_width(PKT_WORDS);
  localparam int BUF_W  = WORD_W + KEEP_W + 1;
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BYTES_PER_WORD - 1);
  localparam logic [WI_W-1:0] LAST_WORD = WI_W'(PKT_WORDS - 1);

  state_e              state_q, state_d;
  logic                rd_pend_q, rd_pend_d;
  logic [BI_W-1:0]     byte_idx_q, byte_idx_d;
  logic [WI_W-1:0]     word_idx_q, word_idx_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [15:0]         pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]    fill_q;

  logic                push, push_last, in_ready, completes, room, rd_en;
  logic [WORD_W-1:0]   push_data, word_in;
  logic [KEEP_W-1:0]   push_keep;
  logic [1:0]          skid_count;
  logic [BUF_W-1:0]    skid_out;

  // A byte already in flight that completes a word will claim a buffer slot.
  assign completes = rd_pend_q && (byte_idx_q == LAST_BYTE);
  assign room      = completes ? (skid_count == 2'd0) : (skid_count < 2'd2);
  assign rd_en     = (state_q == ST_RUN) && enable && !fifo_empty && room;

  assign fifo_rd_en   = rd_en;
  assign busy         = (state_q != ST_IDLE) || (skid_count != 2'd0);
  assign pkt_done_cnt = pkt_cnt_q;
  assign fill_level   = fill_q;
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = skid_out;

  always_comb begin
    word_in = data_q;
    word_in[32'(byte_idx_q) * DATA_W +: DATA_W] = fifo_dout;
  end

  always_comb begin
    state_d    = state_q;
    rd_pend_d  = rd_en;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    data_d     = data_q;
    pkt_cnt_d  = pkt_cnt_q;
    push       = 1'b0;
    push_data  = '0;
    push_keep  = '0;
    push_last  = 1'b0;

    if (rd_pend_q) begin
      if (byte_idx_q == LAST_BYTE) begin
        push       = 1'b1;
        push_data  = word_in;
        push_keep  = '1;
        push_last  = (word_idx_q == LAST_WORD);
        byte_idx_d = '0;
        data_d     = '0;
        if (word_idx_q == LAST_WORD) begin
          word_idx_d = '0;
          pkt_cnt_d  = pkt_cnt_q + 16'd1;
        end else begin
          word_idx_d = word_idx_q + WI_W'(1);
        end
      end else begin
        data_d     = word_in;
        byte_idx_d = byte_idx_q + BI_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (flush) state_d = ST_FLUSH;
        else if (!enable && byte_idx_q == '0 && !rd_pend_q) state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        // Termination waits until the last read byte has landed in the packer.
        if (!rd_pend_q) begin
          if (byte_idx_q != '0) begin
            if (in_ready) begin
              push       = 1'b1;
              push_data  = data_q;
              push_keep  = KEEP_W'(keep_mask(32'(byte_idx_q)));
              push_last  = 1'b1;
              byte_idx_d = '0;
              word_idx_d = '0;
              data_d     = '0;
              pkt_cnt_d  = pkt_cnt_q + 16'd1;
              state_d    = ST_IDLE;
            end
          end else if (word_idx_q != '0) begin
            if (in_ready) begin
              push       = 1'b1;
              push_last  = 1'b1;
              word_idx_d = '0;
              pkt_cnt_d  = pkt_cnt_q + 16'd1;
              state_d    = ST_IDLE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_pend_q  <= 1'b0;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      data_q     <= '0;
      pkt_cnt_q  <= '0;
      fill_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      data_q     <= data_d;
      pkt_cnt_q  <= pkt_cnt_d;
      fill_q     <= fifo_rd_data_count;
    end
  end

  axis_skid_buf #(.W(BUF_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (push),
    .in_data   ({push_last, push_keep, push_data}),
    .in_ready  (in_ready),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_data  (skid_out),
    .count     (skid_count)
  );

endmodule

// File: tb/tb_afifo_axis_reader.sv
// tb/tb_afifo_axis_reader.sv - directed and scoreboard bench for afifo_axis_reader
module tb_afifo_axis_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, enable = 1'b0, flush = 1'b0, fifo_clear = 1'b0;
  logic tready_man = 1'b1, tready_rnd = 1'b0, rnd_mode = 1'b0;
  logic tready;
  assign tready = rnd_mode ? tready_rnd : tready_man;

  logic [7:0] mem [0:8191];
  int wr_ptr = 0;
  int rd_ptr0 = 0, rd_ptr1 = 0;
  logic [7:0] dout0 = '0, dout1 = '0;
  logic rd_en0, rd_en1, empty0, empty1;
  logic [9:0] cnt0, cnt1, fill0, fill1;
  logic [31:0] tdata0, tdata1;
  logic [3:0] tkeep0, tkeep1;
  logic tlast0, tlast1, tvalid0, tvalid1, busy0, busy1;
  logic [15:0] pkt0, pkt1;

  assign empty0 = (rd_ptr0 == wr_ptr);
  assign empty1 = (rd_ptr1 == wr_ptr);
  assign cnt0 = 10'(wr_ptr - rd_ptr0);
  assign cnt1 = 10'(wr_ptr - rd_ptr1);

  always @(posedge clk) begin
    if (fifo_clear) rd_ptr0 <= wr_ptr;
    else if (rd_en0) begin dout0 <= mem[rd_ptr0[12:0]]; rd_ptr0 <= rd_ptr0 + 1; end
  end
  always @(posedge clk) begin
    if (fifo_clear) rd_ptr1 <= wr_ptr;
    else if (rd_en1) begin dout1 <= mem[rd_ptr1[12:0]]; rd_ptr1 <= rd_ptr1 + 1; end
  end
  always @(posedge clk) begin
    #1;
    tready_rnd = ($urandom_range(0, 9) < 3);
  end

  afifo_axis_reader #(.PKT_WORDS(256)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .fifo_dout(dout0), .fifo_empty(empty0), .fifo_rd_data_count(cnt0),
    .fifo_rd_en(rd_en0), .m_axis_tdata(tdata0), .m_axis_tkeep(tkeep0),
    .m_axis_tlast(tlast0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready),
    .busy(busy0), .pkt_done_cnt(pkt0), .fill_level(fill0));

  afifo_axis_reader #(.PKT_WORDS(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .fifo_dout(dout1), .fifo_empty(empty1), .fifo_rd_data_count(cnt1),
    .fifo_rd_en(rd_en1), .m_axis_tdata(tdata1), .m_axis_tkeep(tkeep1),
    .m_axis_tlast(tlast1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready),
    .busy(busy1), .pkt_done_cnt(pkt1), .fill_level(fill1));

  // Beat monitor and protocol watchers, sampled on the falling edge.
  int n0 = 0, n1 = 0;
  logic [36:0] m0 [0:4095];
  logic [36:0] m1 [0:4095];
  int viol_rd_empty = 0, viol_stable = 0, viol_cnt = 0;
  logic hold_q = 1'b0;
  logic [36:0] hold_beat = '0;

  always @(negedge clk) begin
    if (tvalid0 && tready && n0 < 4096) begin m0[n0] = {tlast0, tkeep0, tdata0}; n0++; end
    if (tvalid1 && tready && n1 < 4096) begin m1[n1] = {tlast1, tkeep1, tdata1}; n1++; end
    if ((rd_en0 && empty0) || (rd_en1 && empty1)) viol_rd_empty++;
    if (dut.skid_count > 2'd2) viol_cnt++;
    if (rst) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q && (!tvalid0 || {tlast0, tkeep0, tdata0} != hold_beat)) viol_stable++;
      hold_q    = tvalid0 && !tready;
      hold_beat = {tlast0, tkeep0, tdata0};
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fifo_clear = 1'b1; enable = 1'b0; flush = 1'b0;
    rnd_mode = 1'b0; tready_man = 1'b1;
    repeat (2) tick();
    fifo_clear = 1'b0; rst = 1'b0;
    tick();
  endtask

  typedef struct {
    int          nbytes;
    bit          use_dut2;
    bit          do_flush;
    int          nbeats;
    logic [36:0] beat [4];
    int          pkts;
  } scn_t;

  scn_t scn [4];
  logic [7:0] exp_bytes [0:4095];

  initial begin
    int base, got, cyc, p;
    logic [36:0] e;

    scn[0].nbytes = 16; scn[0].use_dut2 = 0; scn[0].do_flush = 0; scn[0].nbeats = 4; scn[0].pkts = 0;
    scn[0].beat = '{{1'b0, 4'hF, 32'h03020100}, {1'b0, 4'hF, 32'h07060504},
                    {1'b0, 4'hF, 32'h0B0A0908}, {1'b0, 4'hF, 32'h0F0E0D0C}};
    scn[1].nbytes = 16; scn[1].use_dut2 = 1; scn[1].do_flush = 0; scn[1].nbeats = 4; scn[1].pkts = 2;
    scn[1].beat = '{{1'b0, 4'hF, 32'h03020100}, {1'b1, 4'hF, 32'h07060504},
                    {1'b0, 4'hF, 32'h0B0A0908}, {1'b1, 4'hF, 32'h0F0E0D0C}};
    scn[2].nbytes = 6; scn[2].use_dut2 = 0; scn[2].do_flush = 1; scn[2].nbeats = 2; scn[2].pkts = 1;
    scn[2].beat = '{{1'b0, 4'hF, 32'h03020100}, {1'b1, 4'h3, 32'h00000504}, 37'h0, 37'h0};
    scn[3].nbytes = 8; scn[3].use_dut2 = 0; scn[3].do_flush = 1; scn[3].nbeats = 3; scn[3].pkts = 1;
    scn[3].beat = '{{1'b0, 4'hF, 32'h03020100}, {1'b0, 4'hF, 32'h07060504},
                    {1'b1, 4'h0, 32'h00000000}, 37'h0};

    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("reset outputs", {tvalid0, rd_en0, busy0, tlast0, tkeep0, tdata0, pkt0, fill0},
        64'h0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin mem[wr_ptr[12:0]] = 8'hA0; wr_ptr++; end
    repeat (3) tick();
    chk("fill_level", 64'(fill0), 64'd5);

    for (int s = 0; s < 4; s++) begin
      do_reset();
      base = scn[s].use_dut2 ? n1 : n0;
      for (int i = 0; i < scn[s].nbytes; i++) begin
        mem[wr_ptr[12:0]] = 8'(i);
        wr_ptr++;
      end
      enable = 1'b1;
      repeat (30) tick();
      if (scn[s].do_flush) begin
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (10) tick();
      end
      enable = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      got = (scn[s].use_dut2 ? n1 : n0) - base;
      chk($sformatf("s%0d beat count", s), 64'(got), 64'(scn[s].nbeats));
      for (int b = 0; b < scn[s].nbeats; b++) begin
        if (b < got)
          chk($sformatf("s%0d beat%0d {last,keep,data}", s, b),
              64'(scn[s].use_dut2 ? m1[base + b] : m0[base + b]), 64'(scn[s].beat[b]));
      end
      chk($sformatf("s%0d pkt_done_cnt", s), 64'(scn[s].use_dut2 ? pkt1 : pkt0), 64'(scn[s].pkts));
      chk($sformatf("s%0d busy after disable", s), 64'(scn[s].use_dut2 ? busy1 : busy0), 64'd0);
    end

    // Random tready with a byte scoreboard
    do_reset();
    for (int i = 0; i < 4096; i++) begin
      exp_bytes[i] = 8'($urandom_range(0, 255));
      mem[wr_ptr[12:0]] = exp_bytes[i];
      wr_ptr++;
    end
    base = n0;
    rnd_mode = 1'b1;
    enable = 1'b1;
    cyc = 0;
    while ((n0 - base) < 1024 && cyc < 20000) begin tick(); cyc++; end
    got = n0 - base;
    chk("rand beat count", 64'(got), 64'd1024);
    for (int w = 0; w < 1024; w++) begin
      if (w < got) begin
        e = {(w % 256 == 255), 4'hF, exp_bytes[4*w+3], exp_bytes[4*w+2],
             exp_bytes[4*w+1], exp_bytes[4*w]};
        chk($sformatf("rand beat%0d", w), 64'(m0[base + w]), 64'(e));
      end
    end
    chk("rand pkt_done_cnt", 64'(pkt0), 64'd4);
    rnd_mode = 1'b0;
    enable = 1'b0;
    repeat (5) tick();
    chk("rd_en while empty", 64'(viol_rd_empty), 64'd0);
    chk("beat stable under backpressure", 64'(viol_stable), 64'd0);
    chk("buffer count <= 2", 64'(viol_cnt), 64'd0);

    // Reset mid-word while a beat is stalled
    do_reset();
    tready_man = 1'b0;
    for (int i = 0; i < 16; i++) begin mem[wr_ptr[12:0]] = 8'(8'h40 + i); wr_ptr++; end
    enable = 1'b1;
    cyc = 0;
    while (!tvalid0 && cyc < 40) begin tick(); cyc++; end
    chk("rst test tvalid seen", 64'(tvalid0), 64'd1);
    tick();
    rst = 1'b1; enable = 1'b0;
    tick();
    chk("after rst {tvalid,rd_en,busy,pkt}", {tvalid0, rd_en0, busy0, pkt0}, 64'h0);
    rst = 1'b0;
    p = rd_ptr0;
    tready_man = 1'b1;
    base = n0;
    enable = 1'b1;
    cyc = 0;
    while (n0 == base && cyc < 40) begin tick(); cyc++; end
    @(negedge clk);
    chk("after rst beat seen", 64'(n0 - base > 0), 64'd1);
    if (n0 > base) begin
      e = {1'b0, 4'hF, mem[13'(p + 3)], mem[13'(p + 2)], mem[13'(p + 1)], mem[13'(p)]};
      chk("after rst first beat", 64'(m0[base]), 64'(e));
    end
    enable = 1'b0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
